// File: rtl/multicore_system_core_ram_copier_if.sv
// Avalon-MM bundle between the copier (master) and a word-addressed core RAM (slave).
interface multicore_system_core_ram_copier_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/multicore_system_core_ram_copier.sv
// Block COPY / FILL engine mastering a fixed-latency core RAM over Avalon-MM.
module multicore_system_core_ram_copier #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dst_addr,
    input  logic [LEN_W-1:0]     len,
    input  logic [DATA_W-1:0]    fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [LEN_W-1:0]     words_done,
    multicore_system_core_ram_copier_if.master avm
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    logic [2:0]        r_state;
    logic              r_mode;
    logic              r_abort_pend;
    logic              r_aborted;
    logic [1:0]        r_lat_cnt;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_words_done;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_data;

    logic w_abort;
    logic w_wr_acc;
    logic w_lat_done;
    logic w_last;

    // An abort raised in the deciding cycle itself counts as pending.
    assign w_abort    = r_abort_pend | abort;
    assign w_wr_acc   = (r_state == S_WR_REQ) && !avm.waitrequest;
    assign w_lat_done = (r_state == S_RD_WAIT) && (r_lat_cnt == LAT_LAST);
    assign w_last     = (r_remaining == LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_aborted    <= 1'b0;
            r_lat_cnt    <= 2'd0;
            r_remaining  <= '0;
            r_words_done <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_abort_pend <= 1'b0;
                    if (start) begin
                        r_mode       <= mode;
                        r_remaining  <= len;
                        r_words_done <= '0;
                        r_aborted    <= 1'b0;
                        if (len == '0)
                            r_state <= S_FIN;
                        else if (mode)
                            r_state <= S_WR_REQ;
                        else
                            r_state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (abort)
                        r_abort_pend <= 1'b1;
                    if (!avm.waitrequest) begin
                        r_lat_cnt <= 2'd0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (abort)
                        r_abort_pend <= 1'b1;
                    if (r_lat_cnt == LAT_LAST) begin
                        if (w_abort) begin
                            r_aborted <= 1'b1;
                            r_state   <= S_FIN;
                        end else begin
                            r_state <= S_WR_REQ;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                S_WR_REQ: begin
                    if (abort)
                        r_abort_pend <= 1'b1;
                    if (!avm.waitrequest) begin
                        r_words_done <= r_words_done + LEN_W'(1);
                        r_remaining  <= r_remaining - LEN_W'(1);
                        if (w_last || w_abort) begin
                            // Abort landing on the final word is a normal completion.
                            r_aborted <= w_abort && !w_last;
                            r_state   <= S_FIN;
                        end else if (!r_mode) begin
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_FIN: begin
                    r_abort_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pointers and data are only observable while a request is active.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && start) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_fill <= fill_data;
        end
        if (w_wr_acc) begin
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
        end
        if (w_lat_done)
            r_data <= avm.readdata;
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign aborted    = r_aborted;
    assign words_done = r_words_done;

    assign avm.read       = (r_state == S_RD_REQ);
    assign avm.write      = (r_state == S_WR_REQ);
    assign avm.address    = (r_state == S_RD_REQ) ? r_src :
                            (r_state == S_WR_REQ) ? r_dst : '0;
    assign avm.writedata  = (r_state != S_WR_REQ) ? '0 :
                            r_mode ? r_fill : r_data;
    assign avm.byteenable = '1;

endmodule

// File: tb/tb_multicore_system_core_ram_copier.sv
// Directed vector bench for the core RAM copier against a 1-cycle-latency RAM model.
module tb_multicore_system_core_ram_copier;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 11;

    logic              clk       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              start     = 1'b0;
    logic              abort     = 1'b0;
    logic              mode      = 1'b0;
    logic [ADDR_W-1:0] src_addr  = '0;
    logic [ADDR_W-1:0] dst_addr  = '0;
    logic [LEN_W-1:0]  len       = '0;
    logic [DATA_W-1:0] fill_data = '0;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  words_done;

    logic stall_en = 1'b0;
    logic preload  = 1'b0;
    int   viol     = 0;
    int   n_reads  = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [DATA_W-1:0] mem [0:1023];
    logic [ADDR_W-1:0] wr_a_q [$];
    logic [DATA_W-1:0] wr_d_q [$];

    multicore_system_core_ram_copier_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avm ();

    multicore_system_core_ram_copier #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .avm(avm)
    );

    always #5 clk = ~clk;

    // RAM slave: readdata valid the cycle after the accept edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= 32'(i + 1);
            mem[1023] <= 32'hCAFE_F00D;
            wr_a_q.delete();
            wr_d_q.delete();
            n_reads <= 0;
            avm.readdata <= '0;
        end else begin
            if (avm.read && !avm.waitrequest) begin
                avm.readdata <= mem[avm.address];
                n_reads      <= n_reads + 1;
            end
            if (avm.write && !avm.waitrequest) begin
                mem[avm.address] <= avm.writedata;
                wr_a_q.push_back(avm.address);
                wr_d_q.push_back(avm.writedata);
            end
        end
    end

    // Waitrequest bursts of 0-5 cycles separated by at least one free cycle.
    initial begin
        int left;
        left = 0;
        avm.waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (!stall_en) begin
                avm.waitrequest = 1'b0;
                left = 0;
            end else if (left > 0) begin
                avm.waitrequest = 1'b1;
                left--;
            end else begin
                avm.waitrequest = 1'b0;
                left = $urandom_range(0, 5);
            end
        end
    end

    // Bus protocol watcher: no read/write overlap, requests frozen while stalled.
    initial begin
        logic              p_st;
        logic              p_rd, p_wr;
        logic [ADDR_W-1:0] p_a;
        logic [DATA_W-1:0] p_d;
        p_st = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_a = '0; p_d = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                p_st = 1'b0;
            end else begin
                if (avm.read && avm.write) viol++;
                if (p_st && (avm.read !== p_rd || avm.write !== p_wr ||
                             avm.address !== p_a || avm.writedata !== p_d)) viol++;
                p_st = (avm.read || avm.write) && avm.waitrequest;
                p_rd = avm.read; p_wr = avm.write;
                p_a  = avm.address; p_d = avm.writedata;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic              mode;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] fill;
        logic              stall;
        int                abort_cyc;
        int                restart_cyc;
        logic [LEN_W-1:0]  exp_words;
        logic              exp_ab;
        int                exp_busy;
        int                exp_reads;
        int                exp_writes;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fd;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] ld;
    } vec_t;

    task automatic do_preload();
        @(negedge clk); preload = 1'b1;
        @(negedge clk); preload = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int               k, bcnt, dcnt, vb;
        logic [LEN_W-1:0] wd;
        logic             ab;
        bit               tmo;
        string            p;
        p = $sformatf("v%0d", idx);
        do_preload();
        vb = viol;
        wd = '1; ab = 1'bx;
        stall_en  = v.stall;
        mode      = v.mode;
        src_addr  = v.src;
        dst_addr  = v.dst;
        len       = v.len;
        fill_data = v.fill;
        start     = 1'b1;
        abort     = (v.abort_cyc == 0);
        k = 1; bcnt = 0; dcnt = 0; tmo = 0;
        forever begin
            @(negedge clk);
            start = (k == v.restart_cyc);
            abort = (k == v.abort_cyc);
            if (start) begin
                mode      = ~v.mode;
                src_addr  = v.src + 10'd1;
                dst_addr  = v.dst + 10'h040;
                len       = 11'd5;
                fill_data = ~v.fill;
            end
            #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                wd = words_done;
                ab = aborted;
            end
            if (!busy) break;
            k++;
            if (k > 300) begin
                tmo = 1;
                break;
            end
        end
        start = 1'b0; abort = 1'b0; stall_en = 1'b0;
        if (tmo) check({p, "_timeout"}, 64'(1), 64'(0));
        check({p, "_words"},    64'(wd),   64'(v.exp_words));
        check({p, "_aborted"},  64'(ab),   64'(v.exp_ab));
        check({p, "_done_cnt"}, 64'(dcnt), 64'(1));
        if (v.exp_busy >= 0) check({p, "_busy_cyc"}, 64'(bcnt), 64'(v.exp_busy));
        check({p, "_reads"},    64'(n_reads),       64'(v.exp_reads));
        check({p, "_writes"},   64'(wr_a_q.size()), 64'(v.exp_writes));
        if (v.exp_writes > 0 && wr_a_q.size() > 0) begin
            check({p, "_first_addr"}, 64'(wr_a_q[0]), 64'(v.fa));
            check({p, "_first_data"}, 64'(wr_d_q[0]), 64'(v.fd));
            check({p, "_last_addr"},  64'(wr_a_q[wr_a_q.size()-1]), 64'(v.la));
            check({p, "_last_data"},  64'(wr_d_q[wr_d_q.size()-1]), 64'(v.ld));
        end
        check({p, "_protocol"}, 64'(viol - vb), 64'(0));
        check({p, "_held"},     64'(words_done), 64'(v.exp_words));
    endtask

    initial begin
        vec_t vecs [14];
        int   dseen;

        //         mode  src      dst      len     fill          st  ab  rs  words  ab  busy rd wr first             last
        vecs[0]  = '{1'b1, 10'h000, 10'h010, 11'd4, 32'hA5A5A5A5, 1'b0, -1, -1, 11'd4, 1'b0,  5, 0, 4, 10'h010, 32'hA5A5A5A5, 10'h013, 32'hA5A5A5A5};
        vecs[1]  = '{1'b0, 10'h000, 10'h200, 11'd3, 32'h0,        1'b0, -1, -1, 11'd3, 1'b0, 10, 3, 3, 10'h200, 32'd1,        10'h202, 32'd3};
        vecs[2]  = '{1'b0, 10'h004, 10'h300, 11'd2, 32'h0,        1'b1, -1, -1, 11'd2, 1'b0, -1, 2, 2, 10'h300, 32'd5,        10'h301, 32'd6};
        vecs[3]  = '{1'b1, 10'h000, 10'h3FE, 11'd4, 32'h12345678, 1'b0, -1, -1, 11'd4, 1'b0,  5, 0, 4, 10'h3FE, 32'h12345678, 10'h001, 32'h12345678};
        vecs[4]  = '{1'b0, 10'h000, 10'h100, 11'd0, 32'h0,        1'b0, -1, -1, 11'd0, 1'b0,  1, 0, 0, 10'h000, 32'h0,        10'h000, 32'h0};
        vecs[5]  = '{1'b1, 10'h000, 10'h100, 11'd8, 32'h0F0F0F0F, 1'b0,  2, -1, 11'd2, 1'b1,  3, 0, 2, 10'h100, 32'h0F0F0F0F, 10'h101, 32'h0F0F0F0F};
        vecs[6]  = '{1'b0, 10'h3FF, 10'h005, 11'd2, 32'h0,        1'b0, -1, -1, 11'd2, 1'b0,  7, 2, 2, 10'h005, 32'hCAFEF00D, 10'h006, 32'd1};
        vecs[7]  = '{1'b0, 10'h000, 10'h080, 11'd3, 32'h0,        1'b0,  1, -1, 11'd0, 1'b1,  3, 1, 0, 10'h000, 32'h0,        10'h000, 32'h0};
        vecs[8]  = '{1'b0, 10'h000, 10'h080, 11'd2, 32'h0,        1'b0,  6, -1, 11'd2, 1'b0,  7, 2, 2, 10'h080, 32'd1,        10'h081, 32'd2};
        vecs[9]  = '{1'b1, 10'h000, 10'h0C0, 11'd1, 32'h00000055, 1'b0,  1, -1, 11'd1, 1'b0,  2, 0, 1, 10'h0C0, 32'h55,       10'h0C0, 32'h55};
        vecs[10] = '{1'b1, 10'h000, 10'h0D0, 11'd2, 32'h00000077, 1'b0,  0, -1, 11'd2, 1'b0,  3, 0, 2, 10'h0D0, 32'h77,       10'h0D1, 32'h77};
        vecs[11] = '{1'b1, 10'h000, 10'h020, 11'd3, 32'h11111111, 1'b0, -1,  1, 11'd3, 1'b0,  4, 0, 3, 10'h020, 32'h11111111, 10'h022, 32'h11111111};
        vecs[12] = '{1'b1, 10'h000, 10'h050, 11'd3, 32'h00000099, 1'b1, -1, -1, 11'd3, 1'b0, -1, 0, 3, 10'h050, 32'h99,       10'h052, 32'h99};
        vecs[13] = '{1'b0, 10'h000, 10'h0A0, 11'd3, 32'h0,        1'b0,  3, -1, 11'd1, 1'b1,  4, 1, 1, 10'h0A0, 32'd1,        10'h0A0, 32'd1};

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        check("rst_busy",       64'(busy),           64'(0));
        check("rst_done",       64'(done),           64'(0));
        check("rst_aborted",    64'(aborted),        64'(0));
        check("rst_words",      64'(words_done),     64'(0));
        check("rst_read",       64'(avm.read),       64'(0));
        check("rst_write",      64'(avm.write),      64'(0));
        check("rst_address",    64'(avm.address),    64'(0));
        check("rst_writedata",  64'(avm.writedata),  64'(0));
        check("rst_byteenable", 64'(avm.byteenable), 64'(4'hF));
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a COPY: outputs clear at once, no done pulse.
        do_preload();
        mode = 1'b0; src_addr = 10'h000; dst_addr = 10'h200; len = 11'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        dseen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            if (done) dseen++;
        end
        check("mid_busy_before", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",  64'(busy),        64'(0));
        check("mid_rst_read",  64'(avm.read),    64'(0));
        check("mid_rst_write", 64'(avm.write),   64'(0));
        check("mid_rst_addr",  64'(avm.address), 64'(0));
        check("mid_rst_words", 64'(words_done),  64'(0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            if (done) dseen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (done || busy) dseen++;
        end
        check("mid_rst_no_done", 64'(dseen), 64'(0));
        check("mid_rst_aborted", 64'(aborted), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
